// File: rtl/quad_pkg.sv
// Shared types and helpers for the quad_acc sum-of-squares engine:
// width derivation and fractional word-length truncation.
package quad_pkg;

  typedef enum logic {
    ACC_OFF = 1'b0,
    ACC_ON  = 1'b1
  } acc_mode_e;

  function automatic int w_sq_f(input int iwl, input int fwl);
    return 2 * (iwl + fwl);
  endfunction

  function automatic int w_sum_f(input int w_sq, input int n_ch);
    return w_sq + $clog2(n_ch);
  endfunction

  function automatic int w_out_f(input int w_sum, input int acc_len);
    return w_sum + $clog2(acc_len);
  endfunction

  // Zero the lowest (total_frac - keep_frac) bits; a zero-length mask passes the value through.
  function automatic logic [63:0] fwl_trunc(input logic [63:0] value, input int total_frac,
                                            input int keep_frac);
    logic [63:0] mask;
    mask = (64'd1 << (total_frac - keep_frac)) - 64'd1;
    return value & ~mask;
  endfunction

endpackage

// File: rtl/quad_acc_if.sv
// Input-vector and result valid/ready channels of quad_acc.
interface quad_acc_if #(
  parameter int N_CH  = 4,
  parameter int W_IN  = 14,
  parameter int W_OUT = 32
) ();
  logic                       in_valid;
  logic                       in_ready;
  logic [N_CH-1:0][W_IN-1:0]  in_data;
  logic                       acc_mode;
  logic                       out_valid;
  logic                       out_ready;
  logic [W_OUT-1:0]           out_data;

  modport master (
    output in_valid, in_data, acc_mode, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, acc_mode, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/quad_sq_lane.sv
// One channel: drop the fraction bits below FWL_IN, then square losslessly.
module quad_sq_lane import quad_pkg::*; #(
  parameter int IWL    = 2,
  parameter int FWL    = 12,
  parameter int FWL_IN = 10,
  localparam int W_IN  = IWL + FWL,
  localparam int W_SQ  = w_sq_f(IWL, FWL)
) (
  input  logic [W_IN-1:0] i_x,
  output logic [W_SQ-1:0] o_sq
);

  localparam int DROP = FWL - FWL_IN;

  logic [W_IN-1:0] w_x;

  generate
    if (DROP == 0) begin : g_keep
      assign w_x = i_x;
    end else begin : g_trunc
      assign w_x = {i_x[W_IN-1:DROP], {DROP{1'b0}}};
    end
  endgenerate

  assign o_sq = W_SQ'(w_x) * W_SQ'(w_x);

endmodule

// File: rtl/quad_acc.sv
// N-channel sum-of-squares engine: square (S1), adder tree (S2), output or
// frame accumulation (S3), with the whole pipeline frozen on output backpressure.
module quad_acc import quad_pkg::*; #(
  parameter int N_CH    = 4,
  parameter int IWL     = 2,
  parameter int FWL     = 12,
  parameter int FWL_IN  = 10,
  parameter int FWL_OUT = 13,
  parameter int ACC_LEN = 4
) (
  input  logic         clk,
  input  logic         rstn,
  quad_acc_if.slave    bus
);

  localparam int W_SQ  = w_sq_f(IWL, FWL);
  localparam int W_SUM = w_sum_f(W_SQ, N_CH);
  localparam int W_OUT = w_out_f(W_SUM, ACC_LEN);
  localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

  logic              w_stall;
  logic              w_adv;
  logic [W_SQ-1:0]   w_sq [N_CH];
  logic [W_SUM-1:0]  w_sum;
  logic [W_OUT-1:0]  w_sum_ext;
  logic [W_OUT-1:0]  w_acc_next;
  logic              w_frame_end;

  logic [W_SQ-1:0]   r_s1_sq [N_CH];
  logic              r_s1_valid;
  acc_mode_e         r_s1_mode;
  logic [W_SUM-1:0]  r_s2_sum;
  logic              r_s2_valid;
  acc_mode_e         r_s2_mode;
  logic [W_OUT-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_out_valid;
  logic [W_OUT-1:0]  r_out_data;

  assign w_stall       = r_out_valid & ~bus.out_ready;
  assign w_adv         = ~w_stall;
  assign bus.in_ready  = rstn & w_adv;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    quad_sq_lane #(
      .IWL    (IWL),
      .FWL    (FWL),
      .FWL_IN (FWL_IN)
    ) u_lane (
      .i_x  (bus.in_data[i]),
      .o_sq (w_sq[i])
    );
  end

  // Lossless sum of the registered squares plus next-accumulator selection.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_sum = w_sum + W_SUM'(r_s1_sq[i]);
    end
    w_sum_ext = W_OUT'(r_s2_sum);
    if (r_cnt == '0) begin
      w_acc_next = w_sum_ext;
    end else begin
      w_acc_next = r_acc + w_sum_ext;
    end
    w_frame_end = (r_cnt == CNT_LAST);
  end

  // S1/S2 pipeline registers; they hold while the output is stalled.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= ACC_OFF;
      r_s2_valid <= 1'b0;
      r_s2_mode  <= ACC_OFF;
      r_s2_sum   <= '0;
      for (int i = 0; i < N_CH; i++) begin
        r_s1_sq[i] <= '0;
      end
    end else if (w_adv) begin
      r_s1_valid <= bus.in_valid;
      r_s1_mode  <= acc_mode_e'(bus.acc_mode);
      for (int i = 0; i < N_CH; i++) begin
        r_s1_sq[i] <= w_sq[i];
      end
      r_s2_valid <= r_s1_valid;
      r_s2_mode  <= r_s1_mode;
      r_s2_sum   <= w_sum;
    end
  end

  // S3: pass-through or frame accumulation; a pass-through sample abandons any partial frame.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_adv) begin
      if (r_s2_valid) begin
        if (r_s2_mode == ACC_ON) begin
          if (w_frame_end) begin
            r_out_data  <= W_OUT'(fwl_trunc(64'(w_acc_next), 2 * FWL, FWL_OUT));
            r_out_valid <= 1'b1;
            r_cnt       <= '0;
          end else begin
            r_acc       <= w_acc_next;
            r_cnt       <= r_cnt + CNT_W'(1'b1);
            r_out_valid <= 1'b0;
          end
        end else begin
          r_out_data  <= W_OUT'(fwl_trunc(64'(w_sum_ext), 2 * FWL, FWL_OUT));
          r_out_valid <= 1'b1;
          r_cnt       <= '0;
        end
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_quad_acc.sv
// Directed bench for quad_acc: default build plus two word-length variants.
module tb_quad_acc;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  quad_acc_if #(.N_CH(4), .W_IN(14), .W_OUT(32)) if_a ();
  quad_acc_if #(.N_CH(4), .W_IN(14), .W_OUT(32)) if_b ();
  quad_acc_if #(.N_CH(4), .W_IN(14), .W_OUT(32)) if_c ();

  quad_acc #(.N_CH(4), .IWL(2), .FWL(12), .FWL_IN(10), .FWL_OUT(13), .ACC_LEN(4))
    u_dut_a (.clk(clk), .rstn(rstn), .bus(if_a));
  quad_acc #(.N_CH(4), .IWL(2), .FWL(12), .FWL_IN(12), .FWL_OUT(24), .ACC_LEN(4))
    u_dut_b (.clk(clk), .rstn(rstn), .bus(if_b));
  quad_acc #(.N_CH(4), .IWL(2), .FWL(12), .FWL_IN(12), .FWL_OUT(13), .ACC_LEN(4))
    u_dut_c (.clk(clk), .rstn(rstn), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    if_a.in_valid = 1'b0; if_a.in_data = '0; if_a.acc_mode = 1'b0; if_a.out_ready = 1'b1;
    if_b.in_valid = 1'b0; if_b.in_data = '0; if_b.acc_mode = 1'b0; if_b.out_ready = 1'b1;
    if_c.in_valid = 1'b0; if_c.in_data = '0; if_c.acc_mode = 1'b0; if_c.out_ready = 1'b1;
  endtask

  // Drives n vectors (ch0 only) into DUT a and records output pulses over a window of steps.
  task automatic run_a(input int n, input logic [7:0] modes, input logic [13:0] ch0,
                       input int window, output int pulses, output int first_step,
                       output logic [31:0] data);
    pulses = 0;
    first_step = -1;
    data = 32'h0;
    for (int s = 0; s < window; s++) begin
      if (s < n) begin
        if_a.in_valid = 1'b1;
        if_a.in_data = '0;
        if_a.in_data[0] = ch0;
        if_a.acc_mode = modes[s];
      end else begin
        if_a.in_valid = 1'b0;
      end
      step();
      if (if_a.out_valid) begin
        pulses++;
        if (first_step < 0) first_step = s + 1;
        data = if_a.out_data;
      end
    end
    if_a.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle_all();
    repeat (3) step();
    checks++; if (if_a.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b expected 0", if_a.in_ready); end
    checks++; if (if_a.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", if_a.out_valid); end
    checks++; if (if_a.out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data: got %h expected 0", if_a.out_data); end
    rstn = 1'b1;
    #1;
    checks++; if (if_a.in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready: got %b expected 1", if_a.in_ready); end
    step();
  endtask

  task automatic test_basic();
    if_a.in_valid = 1'b1;
    if_a.acc_mode = 1'b0;
    if_a.in_data = '0;
    if_a.in_data[0] = 14'h1000;
    if_a.in_data[1] = 14'h1000;
    step();
    if_a.in_valid = 1'b0;
    step();
    checks++; if (if_a.out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid: got %b expected 0", if_a.out_valid); end
    step();
    checks++; if (if_a.out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid: got %b expected 1", if_a.out_valid); end
    checks++; if (if_a.out_data !== 32'h0200_0000) begin failures++; $display("FAIL basic_data: got %h expected 02000000", if_a.out_data); end
    step();
    checks++; if (if_a.out_valid !== 1'b0) begin failures++; $display("FAIL basic_one_pulse: got %b expected 0", if_a.out_valid); end
  endtask

  task automatic test_trunc();
    if_a.in_data = '0; if_a.in_data[0] = 14'h1003; if_a.in_valid = 1'b1;
    if_b.in_data = '0; if_b.in_data[0] = 14'h1003; if_b.in_valid = 1'b1;
    if_c.in_data = '0; if_c.in_data[0] = 14'h1003; if_c.in_valid = 1'b1;
    step();
    if_a.in_valid = 1'b0; if_b.in_valid = 1'b0; if_c.in_valid = 1'b0;
    step();
    step();
    checks++; if (if_a.out_valid !== 1'b1 || if_a.out_data !== 32'h0100_0000) begin failures++; $display("FAIL trunc_fwl_in10: got v=%b d=%h expected v=1 d=01000000", if_a.out_valid, if_a.out_data); end
    checks++; if (if_b.out_valid !== 1'b1 || if_b.out_data !== 32'h0100_6009) begin failures++; $display("FAIL trunc_exact: got v=%b d=%h expected v=1 d=01006009", if_b.out_valid, if_b.out_data); end
    checks++; if (if_c.out_valid !== 1'b1 || if_c.out_data !== 32'h0100_6000) begin failures++; $display("FAIL trunc_out13: got v=%b d=%h expected v=1 d=01006000", if_c.out_valid, if_c.out_data); end
    step();
  endtask

  task automatic test_full_scale();
    for (int i = 0; i < 4; i++) begin
      if_a.in_data[i] = 14'h3FFF;
      if_b.in_data[i] = 14'h3FFF;
      if_c.in_data[i] = 14'h3FFF;
    end
    if_a.in_valid = 1'b1; if_b.in_valid = 1'b1; if_c.in_valid = 1'b1;
    step();
    if_a.in_valid = 1'b0; if_b.in_valid = 1'b0; if_c.in_valid = 1'b0;
    step();
    step();
    checks++; if (if_c.out_data !== 32'h3FFE_0000) begin failures++; $display("FAIL full_scale_c: got %h expected 3ffe0000", if_c.out_data); end
    checks++; if (if_b.out_data !== 32'h3FFE_0004) begin failures++; $display("FAIL full_scale_b: got %h expected 3ffe0004", if_b.out_data); end
    checks++; if (if_a.out_data !== 32'h3FF8_0000) begin failures++; $display("FAIL full_scale_a: got %h expected 3ff80000", if_a.out_data); end
    step();
    if_a.in_data = '0; if_b.in_data = '0; if_c.in_data = '0;
  endtask

  task automatic test_accumulate();
    int p, f;
    logic [31:0] d;
    run_a(4, 8'b0000_1111, 14'h1000, 9, p, f, d);
    checks++; if (p !== 1) begin failures++; $display("FAIL acc_pulses: got %0d expected 1", p); end
    checks++; if (f !== 6) begin failures++; $display("FAIL acc_latency: got step %0d expected 6", f); end
    checks++; if (d !== 32'h0400_0000) begin failures++; $display("FAIL acc_data: got %h expected 04000000", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_bp [8];
    int sent, recv, stall_cnt, extra;
    bit prev_stall;
    logic [31:0] held;
    exp_bp = '{32'h0010_0000, 32'h0040_0000, 32'h0090_0000, 32'h0100_0000,
               32'h0190_0000, 32'h0240_0000, 32'h0310_0000, 32'h0400_0000};
    sent = 0; recv = 0; stall_cnt = 0; extra = 0; prev_stall = 1'b0; held = 32'h0;
    if_a.acc_mode = 1'b0;
    for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
      if_a.out_ready = !(cyc >= 4 && cyc <= 8);
      if (sent < 8) begin
        if_a.in_valid = 1'b1;
        if_a.in_data = '0;
        if_a.in_data[0] = 14'((sent + 1) * 1024);
      end else begin
        if_a.in_valid = 1'b0;
      end
      #1;
      if (if_a.out_valid && !if_a.out_ready) begin
        checks++; if (if_a.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready: got %b expected 0 at cycle %0d", if_a.in_ready, cyc); end
        if (prev_stall) begin
          checks++; if (if_a.out_data !== held) begin failures++; $display("FAIL bp_stable: got %h expected %h", if_a.out_data, held); end
        end
        held = if_a.out_data;
        prev_stall = 1'b1;
        stall_cnt++;
      end else begin
        prev_stall = 1'b0;
      end
      if (if_a.out_valid && if_a.out_ready) begin
        checks++; if (if_a.out_data !== exp_bp[recv]) begin failures++; $display("FAIL bp_order[%0d]: got %h expected %h", recv, if_a.out_data, exp_bp[recv]); end
        recv++;
      end
      if (if_a.in_valid && if_a.in_ready) sent++;
      step();
    end
    if_a.in_valid = 1'b0;
    if_a.out_ready = 1'b1;
    checks++; if (recv !== 8) begin failures++; $display("FAIL bp_count: got %0d expected 8", recv); end
    checks++; if (stall_cnt !== 5) begin failures++; $display("FAIL bp_stall_cycles: got %0d expected 5", stall_cnt); end
    for (int k = 0; k < 5; k++) begin
      if (if_a.out_valid) extra++;
      step();
    end
    checks++; if (extra !== 0) begin failures++; $display("FAIL bp_duplicate: got %0d extra results expected 0", extra); end
  endtask

  task automatic test_mode_switch();
    int p, f;
    logic [31:0] d;
    run_a(3, 8'b0000_0011, 14'h1000, 8, p, f, d);
    checks++; if (p !== 1) begin failures++; $display("FAIL switch_pulses: got %0d expected 1", p); end
    checks++; if (f !== 5) begin failures++; $display("FAIL switch_latency: got step %0d expected 5", f); end
    checks++; if (d !== 32'h0100_0000) begin failures++; $display("FAIL switch_data: got %h expected 01000000", d); end
    run_a(4, 8'b0000_1111, 14'h1000, 9, p, f, d);
    checks++; if (p !== 1 || f !== 6) begin failures++; $display("FAIL switch_cnt_reset: got pulses=%0d step=%0d expected pulses=1 step=6", p, f); end
    checks++; if (d !== 32'h0400_0000) begin failures++; $display("FAIL switch_frame_data: got %h expected 04000000", d); end
  endtask

  task automatic test_reset_mid_frame();
    int p, f;
    logic [31:0] d;
    run_a(2, 8'b0000_0011, 14'h1000, 4, p, f, d);
    checks++; if (p !== 0) begin failures++; $display("FAIL midrst_partial: got %0d pulses expected 0", p); end
    rstn = 1'b0;
    step();
    checks++; if (if_a.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid: got %b expected 0", if_a.out_valid); end
    rstn = 1'b1;
    run_a(4, 8'b0000_1111, 14'h1000, 9, p, f, d);
    checks++; if (p !== 1 || f !== 6) begin failures++; $display("FAIL midrst_frame: got pulses=%0d step=%0d expected pulses=1 step=6", p, f); end
    checks++; if (d !== 32'h0400_0000) begin failures++; $display("FAIL midrst_data: got %h expected 04000000", d); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rstn = 1'b0;
    idle_all();
    test_reset();
    test_basic();
    test_trunc();
    test_full_scale();
    test_accumulate();
    test_back_to_back();
    test_mode_switch();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
